run_ctrl: RTL and testbench
===========================

RUN_CTRL -- requirements
Module: run_ctrl

Interface
REQ-001 Parameter: HOLD_CYCLES, 2, number of cycles core_reset is held high after start is accepted (range 1-255).
REQ-002 Parameter: TIMEOUT_CYCLES, 16'hFFFF, maximum RUN cycles before the run is abandoned (range 1-65535).
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 Port: clk  in  1  sole clock; all state changes on rising edge.
REQ-005 Port: reset  in  1  synchronous, active-high block reset.
REQ-006 Port: start  in  1  one-cycle request to launch a program run.
REQ-007 Port: prog_sel  in  2  program ID (0 = product, 1 = pattern count, 2 = min distance, 3 = reserved), sampled with start.
REQ-008 Port: core_done  in  1  completion flag from core.
REQ-009 Port: mem_rdata  in  8  data-memory read data, valid the cycle after mem_raddr is presented.
REQ-010 Port: core_reset  out  1  reset/start line to core; high = core parked.
REQ-011 Port: mem_raddr  out  8  data-memory read address.
REQ-012 Port: result  out  16  fetched program result.
REQ-013 Port: result_valid  out  1  one-cycle pulse when result, cycle_ct and timeout are final.
REQ-014 Port: busy  out  1  high in every state except IDLE.
REQ-015 Port: cycle_ct  out  16  RUN cycles for the last or current run.
REQ-016 Port: timeout  out  1  last run ended without core_done.

Function
REQ-017 States SHALL be IDLE, HOLD, RUN, FETCH_HI, FETCH_LO and REPORT.
REQ-018 IDLE: core_reset = 1. start = 1 → latch prog_sel; clear cycle_ct, timeout and result; enter HOLD.
REQ-019 IDLE: prog_sel = 3 with start → treat as accepted start; skip HOLD and RUN; go to REPORT with result = 0 and timeout = 0.
REQ-020 HOLD: core_reset = 1 for exactly HOLD_CYCLES cycles, then enter RUN; core_done is ignored.
REQ-021 RUN: core_reset = 0; cycle_ct increments every RUN cycle, saturating at 16'hFFFF.
REQ-022 RUN: core_done is sampled every cycle, including the first. core_done = 1 → enter FETCH_HI; that cycle is counted.
REQ-023 RUN: cycle_ct reaches TIMEOUT_CYCLES with core_done = 0 → set timeout = 1, result = 0, enter REPORT. If core_done = 1 in the same cycle, done wins.
REQ-024 Read addresses by program: prog 0 → hi = 4, lo = 5; prog 1 → lo = 7, hi byte forced 0; prog 2 → lo = 127, hi byte forced 0.
REQ-025 FETCH_HI: drive the hi address, or skip directly to FETCH_LO for prog 1 and prog 2.
REQ-026 FETCH_LO: drive the lo address and capture the hi byte from mem_rdata. Exit is one cycle later, capturing the lo byte, then enter REPORT.
REQ-027 Latency: the core_done cycle to the result_valid pulse SHALL be 4 cycles for prog 0 and 3 cycles for prog 1 and prog 2.
REQ-028 core_reset SHALL return to 1 on the cycle after core_done is sampled, and SHALL stay 1 through FETCH_*, REPORT and IDLE.
REQ-029 REPORT: result_valid = 1 for exactly one cycle, then enter IDLE.
REQ-030 result, cycle_ct and timeout SHALL hold their values in IDLE until the next accepted start.
REQ-031 start while busy = 1 SHALL be ignored, with no queuing.
REQ-032 mem_raddr SHALL be 0 outside the FETCH states.

Reset
REQ-033 Reset SHALL override everything, including mid-run, forcing state = IDLE, core_reset = 1, busy = 0, result_valid = 0, result = 0, cycle_ct = 0, timeout = 0 and mem_raddr = 0.
REQ-034 start asserted in the same cycle as reset SHALL be ignored.

Configuration
REQ-035 Macro RUN_CTRL_CHECK_EN SHALL control the result-check feature.
- Defined: add input expected[15:0], latched when start is accepted, and output pass[0:0].
- pass = 1 with result_valid when result == expected and timeout = 0; otherwise pass = 0.
- pass holds until the next start; pass resets to 0.
REQ-036 Macro RUN_CTRL_CHECK_EN undefined: the expected and pass ports SHALL be absent; all other behaviour is identical.

Verification
REQ-037 Product run: prog_sel = 0, mem[4] = 8'h00, mem[5] = 8'h96, core_done at RUN cycle 37 → result = 16'h0096, cycle_ct = 37, timeout = 0, result_valid 4 cycles after done.
REQ-038 Count run: prog_sel = 1, mem[7] = 8'd9 → result = 16'h0009; run with HOLD_CYCLES = 2 → core_reset high exactly 2 cycles after start, then low until done.
REQ-039 Timeout: TIMEOUT_CYCLES = 100, core_done held 0 → result_valid 1 cycle after RUN cycle 100, timeout = 1, result = 0, cycle_ct = 100, core_reset = 1.
REQ-040 Mid-run events: start pulsed in RUN is ignored (cycle_ct unaffected); reset in RUN cycle 10 → IDLE, core_reset = 1, cycle_ct = 0; a following run with prog_sel = 2 and mem[127] = 3 gives result = 3.
REQ-041 Check feature with RUN_CTRL_CHECK_EN defined: expected = 16'h0096 with result = 16'h0096 → pass = 1; expected = 16'h0095 → pass = 0; a timeout run → pass = 0.

Source files
------------

// File: rtl/run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : run_ctrl
// Purpose  : Sequences one program run on an attached compute core. The core
//            is held in reset for HOLD_CYCLES cycles and then released. RUN
//            cycles are counted until core_done arrives or TIMEOUT_CYCLES is
//            reached. The program result is then read from data memory and
//            reported with a single-cycle result_valid pulse.
// Ports    : clk          - sole clock, rising edge
//            reset        - synchronous, active-high block reset
//            start        - one-cycle run request, honoured only in IDLE
//            prog_sel[1:0]- program ID, sampled with start (3 = reserved)
//            core_done    - completion flag from the core
//            mem_rdata[7:0]- memory read data, one cycle after mem_raddr
//            core_reset   - core reset/start line, high = core parked
//            mem_raddr[7:0]- memory read address, 0 outside the fetch states
//            result[15:0] - fetched program result
//            result_valid - one-cycle pulse when result/cycle_ct/timeout final
//            busy         - high in every state except IDLE
//            cycle_ct[15:0]- RUN cycles of the last or current run
//            timeout      - last run ended without core_done
//            expected[15:0], pass - only with RUN_CTRL_CHECK_EN defined
// Options  : RUN_CTRL_CHECK_EN - adds the expected input and the pass output
// Revision : 1.0 - initial release
// ============================================================================
module run_ctrl #(
    parameter int HOLD_CYCLES    = 2,
    parameter int TIMEOUT_CYCLES = 16'hFFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  prog_sel,
    input  logic        core_done,
    input  logic [7:0]  mem_rdata,
    output logic        core_reset,
    output logic [7:0]  mem_raddr,
    output logic [15:0] result,
    output logic        result_valid,
    output logic        busy,
    output logic [15:0] cycle_ct,
`ifdef RUN_CTRL_CHECK_EN
    input  logic [15:0] expected,
    output logic        pass,
`endif
    output logic        timeout
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_HOLD     = 3'd1;
    localparam logic [2:0] S_RUN      = 3'd2;
    localparam logic [2:0] S_FETCH_HI = 3'd3;
    localparam logic [2:0] S_FETCH_LO = 3'd4;
    localparam logic [2:0] S_REPORT   = 3'd5;

    localparam logic [7:0]  c_hold_last = 8'(HOLD_CYCLES - 1);
    localparam logic [15:0] c_timeout   = 16'(TIMEOUT_CYCLES);
    localparam logic [7:0]  c_addr_hi_p0 = 8'd4;

    logic [2:0]  r_state;
    logic [2:0]  w_state_nxt;
    logic [1:0]  r_prog;
    logic [7:0]  r_hold_ct;
    logic        r_lo_phase;   // second FETCH_LO cycle: lo byte is on mem_rdata
    logic [15:0] r_result;
    logic [15:0] r_cycle_ct;
    logic        r_timeout;
    logic [15:0] w_ct_inc;
    logic        w_ct_limit;
    logic [7:0]  w_lo_addr;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_ct_inc    = (r_cycle_ct == 16'hFFFF) ? r_cycle_ct : r_cycle_ct + 16'd1;
        w_ct_limit  = (w_ct_inc >= c_timeout);
        w_state_nxt = r_state;

        case (r_prog)
            2'd0:    w_lo_addr = 8'd5;
            2'd1:    w_lo_addr = 8'd7;
            2'd2:    w_lo_addr = 8'd127;
            default: w_lo_addr = 8'd0;
        endcase

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    // Reserved program: accepted, but nothing to run or fetch.
                    w_state_nxt = (prog_sel == 2'd3) ? S_REPORT : S_HOLD;
                end
            end
            S_HOLD: begin
                if (r_hold_ct == c_hold_last) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                // Done has priority over a timeout in the same cycle.
                if (core_done) begin
                    // Programs 1 and 2 have a forced-zero hi byte, so no hi read.
                    w_state_nxt = (r_prog == 2'd0) ? S_FETCH_HI : S_FETCH_LO;
                end else if (w_ct_limit) begin
                    w_state_nxt = S_REPORT;
                end
            end
            S_FETCH_HI: w_state_nxt = S_FETCH_LO;
            S_FETCH_LO: begin
                if (r_lo_phase) begin
                    w_state_nxt = S_REPORT;
                end
            end
            S_REPORT:   w_state_nxt = S_IDLE;
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_prog     <= 2'd0;
            r_hold_ct  <= 8'd0;
            r_lo_phase <= 1'b0;
            r_result   <= 16'd0;
            r_cycle_ct <= 16'd0;
            r_timeout  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_prog     <= prog_sel;
                        r_hold_ct  <= 8'd0;
                        r_result   <= 16'd0;
                        r_cycle_ct <= 16'd0;
                        r_timeout  <= 1'b0;
                    end
                end
                S_HOLD: begin
                    r_hold_ct <= r_hold_ct + 8'd1;
                end
                S_RUN: begin
                    r_cycle_ct <= w_ct_inc;
                    r_lo_phase <= 1'b0;
                    if (!core_done && w_ct_limit) begin
                        r_timeout <= 1'b1;
                        r_result  <= 16'd0;
                    end
                end
                S_FETCH_LO: begin
                    r_lo_phase <= 1'b1;
                    if (!r_lo_phase) begin
                        // Data for the hi address driven in FETCH_HI.
                        r_result[15:8] <= (r_prog == 2'd0) ? mem_rdata : 8'd0;
                    end else begin
                        r_result[7:0] <= mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    always_comb begin
        core_reset   = (r_state != S_RUN);
        busy         = (r_state != S_IDLE);
        result_valid = (r_state == S_REPORT);
        case (r_state)
            S_FETCH_HI: mem_raddr = c_addr_hi_p0;
            S_FETCH_LO: mem_raddr = w_lo_addr;
            default:    mem_raddr = 8'd0;
        endcase
    end

    assign result   = r_result;
    assign cycle_ct = r_cycle_ct;
    assign timeout  = r_timeout;

`ifdef RUN_CTRL_CHECK_EN
    // ------------------------------------------------------------------------
    // Result check: pass is live during REPORT and held afterwards
    // ------------------------------------------------------------------------
    logic [15:0] r_expected;
    logic        r_pass;
    logic        w_match;

    always_comb begin
        w_match = (r_result == r_expected) && !r_timeout;
        pass    = (r_state == S_REPORT) ? w_match : r_pass;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_expected <= 16'd0;
            r_pass     <= 1'b0;
        end else if (r_state == S_IDLE && start) begin
            r_expected <= expected;
            r_pass     <= 1'b0;
        end else if (r_state == S_REPORT) begin
            r_pass <= w_match;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_run_ctrl
// Purpose  : Directed self-checking bench for run_ctrl. Expected run results
//            are queued when a run is launched and popped when result_valid
//            is seen. Inputs change and outputs are sampled on the falling
//            clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_run_ctrl;

    localparam int HOLD    = 2;
    localparam int TIMEOUT = 100;

    typedef struct packed {
        logic [15:0] res;
        logic [15:0] ct;
        logic        to;
        logic        ps;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  prog_sel = 2'd0;
    logic        core_done = 1'b0;
    logic [7:0]  mem_rdata = 8'd0;
    logic        core_reset;
    logic [7:0]  mem_raddr;
    logic [15:0] result;
    logic        result_valid;
    logic        busy;
    logic [15:0] cycle_ct;
    logic        timeout;
    logic [15:0] exp_in = 16'd0;
`ifdef RUN_CTRL_CHECK_EN
    logic [15:0] expected;
    logic        pass;
    assign expected = exp_in;
`endif

    logic [7:0] mem [256];
    exp_t       sb [$];
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    // Data memory with one-cycle read latency.
    always @(posedge clk) mem_rdata <= mem[mem_raddr];

    run_ctrl #(
        .HOLD_CYCLES    (HOLD),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .prog_sel     (prog_sel),
        .core_done    (core_done),
        .mem_rdata    (mem_rdata),
        .core_reset   (core_reset),
        .mem_raddr    (mem_raddr),
        .result       (result),
        .result_valid (result_valid),
        .busy         (busy),
        .cycle_ct     (cycle_ct),
`ifdef RUN_CTRL_CHECK_EN
        .expected     (expected),
        .pass         (pass),
`endif
        .timeout      (timeout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Launch one run and follow it to its report. done_at = 0 means the core
    // never signals done; start_at pulses a stray start in that RUN cycle.
    task automatic do_run(input logic [1:0] prog, input int done_at,
                          input logic [15:0] exp_res, input logic [15:0] exp_ct,
                          input logic exp_to, input int exp_lat,
                          input logic [15:0] exp_val, input logic exp_pass,
                          input int start_at);
        exp_t       e;
        int         lat;
        logic [7:0] addr1;
        e.res = exp_res;
        e.ct  = exp_ct;
        e.to  = exp_to;
        e.ps  = exp_pass;
        addr1 = (exp_to || prog == 2'd3) ? 8'd0 :
                (prog == 2'd0) ? 8'd4 : (prog == 2'd1) ? 8'd7 : 8'd127;

        @(negedge clk);
        start    = 1'b1;
        prog_sel = prog;
        exp_in   = exp_val;
        sb.push_back(e);

        if (prog != 2'd3) begin
            for (int i = 0; i < HOLD; i++) begin
                @(negedge clk);
                start = 1'b0;
                chk("hold_core_reset", core_reset, 1);
            end
            for (int k = 1; k <= TIMEOUT; k++) begin
                @(negedge clk);
                start = (k == start_at);
                chk("run_core_reset", core_reset, 0);
                core_done = (k == done_at);
                if (k == done_at) break;
            end
        end

        lat = 0;
        do begin
            @(negedge clk);
            start     = 1'b0;
            core_done = 1'b0;
            lat++;
            if (lat == 1) begin
                chk("post_run_core_reset", core_reset, 1);
                chk("first_fetch_addr", mem_raddr, addr1);
            end
        end while (!result_valid && lat < 12);

        chk("result_valid_seen", result_valid, 1);
        chk("latency", lat, exp_lat);
        chk("sb_not_empty", (sb.size() > 0), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("result", result, e.res);
            chk("cycle_ct", cycle_ct, e.ct);
            chk("timeout", timeout, e.to);
`ifdef RUN_CTRL_CHECK_EN
            chk("pass", pass, e.ps);
`endif
        end

        // Back in IDLE: pulse over, results held.
        @(negedge clk);
        chk("idle_valid", result_valid, 0);
        chk("idle_busy", busy, 0);
        chk("idle_addr", mem_raddr, 0);
        chk("idle_core_reset", core_reset, 1);
        chk("held_result", result, e.res);
        chk("held_cycle_ct", cycle_ct, e.ct);
        chk("held_timeout", timeout, e.to);
`ifdef RUN_CTRL_CHECK_EN
        chk("held_pass", pass, e.ps);
`endif
    endtask

    initial begin
        foreach (mem[i]) mem[i] = 8'(i ^ 8'h5A);

        // Reset with a concurrent start that must be ignored.
        start = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_core_reset", core_reset, 1);
        chk("rst_valid", result_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_cycle_ct", cycle_ct, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_addr", mem_raddr, 0);
`ifdef RUN_CTRL_CHECK_EN
        chk("rst_pass", pass, 0);
`endif
        start = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", busy, 0);

        // Product runs.
        mem[4] = 8'h00; mem[5] = 8'h96;
        do_run(2'd0, 37, 16'h0096, 16'd37, 1'b0, 4, 16'h0096, 1'b1, 0);
        do_run(2'd0, 1,  16'h0096, 16'd1,  1'b0, 4, 16'h0095, 1'b0, 0);
        mem[4] = 8'hA5; mem[5] = 8'h3C;
        do_run(2'd0, 20, 16'hA53C, 16'd20, 1'b0, 4, 16'hA53C, 1'b1, 0);

        // Count run with a stray start in RUN cycle 5.
        mem[7] = 8'd9;
        do_run(2'd1, 12, 16'h0009, 16'd12, 1'b0, 3, 16'h0009, 1'b1, 5);

        // Timeout run, then reserved program (clears the stale timeout).
        do_run(2'd2, 0, 16'h0000, 16'd100, 1'b1, 1, 16'h0000, 1'b0, 0);
        do_run(2'd3, 0, 16'h0000, 16'd0,   1'b0, 1, 16'h0000, 1'b1, 0);

        // Reset during RUN cycle 10.
        @(negedge clk);
        start    = 1'b1;
        prog_sel = 2'd2;
        for (int i = 0; i < HOLD; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 10) begin
                chk("midrun_cycle_ct", cycle_ct, 9);
                reset = 1'b1;
            end
        end
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_core_reset", core_reset, 1);
        chk("midrst_cycle_ct", cycle_ct, 0);
        chk("midrst_timeout", timeout, 0);
        chk("midrst_addr", mem_raddr, 0);
        reset = 1'b0;

        mem[127] = 8'd3;
        do_run(2'd2, 5, 16'h0003, 16'd5, 1'b0, 3, 16'h0003, 1'b1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
